// File: rtl/gpu_flash_pkg.sv
// gpu_flash_pkg: shared state encoding, op codes and timing defaults for the flash arbiter
package gpu_flash_pkg;
   localparam int CNT_W = 10;
   localparam int DEF_ADDR_W = 20;
   localparam int DEF_RD_WAIT = 4;
   localparam int DEF_WR_PULSE = 3;
   localparam int DEF_RST_PULSE = 8;
   localparam int DEF_BUSY_TMO = 1023;
   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WR, S_WR_BUSY, S_RST, S_RST_BUSY, S_DONE
   } state_e;
   typedef enum logic [1:0] {
      OP_RD = 2'b00, OP_WR = 2'b01, OP_RST = 2'b10, OP_BAD = 2'b11
   } op_e;
   function automatic state_e op_state(op_e op);
      return op == OP_RD ? S_RD : op == OP_WR ? S_WR : op == OP_RST ? S_RST : S_DONE;
   endfunction
endpackage

// File: rtl/flash_rr_arb.sv
// flash_rr_arb: two-requester round-robin grant, host wins the first tie after reset
module flash_rr_arb (
   input  logic clk,
   input  logic rst,
   input  logic req_host,
   input  logic req_glyph,
   input  logic take,
   output logic gnt_host,
   output logic gnt_glyph
);
   logic last_grant_q, last_grant_d;
   always_comb begin
      gnt_host = req_host & (~req_glyph | last_grant_q);
      gnt_glyph = req_glyph & ~gnt_host;
      last_grant_d = (take && (gnt_host || gnt_glyph)) ? gnt_glyph : last_grant_q;
   end
   always_ff @(posedge clk) begin
      if (rst) last_grant_q <= 1'b1;
      else last_grant_q <= last_grant_d;
   end
endmodule

// File: rtl/flash_arb.sv
// flash_arb: arbitrates host and glyph ports onto a parallel NOR flash with read/write/reset timing
module flash_arb
   import gpu_flash_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_WAIT = DEF_RD_WAIT,
   parameter int WR_PULSE = DEF_WR_PULSE,
   parameter int RST_PULSE = DEF_RST_PULSE,
   parameter int BUSY_TMO = DEF_BUSY_TMO
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hostReq,
   input  logic [1:0]        hostOp,
   input  logic [ADDR_W-1:0] hostAddr,
   input  logic [7:0]        hostWData,
   output logic              hostAck,
   output logic [7:0]        hostRData,
   output logic              hostErr,
   input  logic              glyphReq,
   input  logic [ADDR_W-1:0] glyphAddr,
   output logic              glyphAck,
   output logic [7:0]        glyphRData,
   output logic [ADDR_W-1:0] flashAddr,
   output logic [7:0]        flashDout,
   output logic              flashDoutEn,
   input  logic [7:0]        flashDin,
   output logic              flashCe_n,
   output logic              flashOe_n,
   output logic              flashWe_n,
   output logic              flashRst_n,
   input  logic              flashRdy,
   output logic              busy
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d, host_rdata_q, host_rdata_d, glyph_rdata_q, glyph_rdata_d;
   logic sel_q, sel_d, err_q, err_d;
   logic host_ack_q, host_ack_d, glyph_ack_q, glyph_ack_d, host_err_q, host_err_d;
   logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, rst_n_q, rst_n_d, dout_en_q, dout_en_d;
   logic gnt_host, gnt_glyph;
   op_e op_d;
   // a port whose ack is showing this cycle is masked so the held req is not re-granted
   flash_rr_arb u_rr (
      .clk      (clk),
      .rst      (rst),
      .req_host (hostReq & ~host_ack_q),
      .req_glyph(glyphReq & ~glyph_ack_q),
      .take     (state_q == S_IDLE),
      .gnt_host (gnt_host),
      .gnt_glyph(gnt_glyph)
   );
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      sel_d = sel_q;
      err_d = err_q;
      host_rdata_d = host_rdata_q;
      glyph_rdata_d = glyph_rdata_q;
      op_d = gnt_glyph ? OP_RD : op_e'(hostOp);
      case (state_q)
         S_IDLE: if (gnt_host || gnt_glyph) begin
            sel_d = gnt_glyph;
            addr_d = gnt_glyph ? glyphAddr : hostAddr;
            wdata_d = gnt_glyph ? wdata_q : hostWData;
            err_d = op_d == OP_BAD;
            state_d = op_state(op_d);
         end
         S_RD: if (cnt_q == '0) begin
            host_rdata_d = sel_q ? host_rdata_q : flashDin;
            glyph_rdata_d = sel_q ? flashDin : glyph_rdata_q;
            state_d = S_DONE;
         end
         S_WR: state_d = cnt_q == '0 ? S_WR_BUSY : S_WR;
         S_RST: state_d = cnt_q == '0 ? S_RST_BUSY : S_RST;
         S_WR_BUSY, S_RST_BUSY: if (flashRdy || cnt_q == '0) begin
            err_d = ~flashRdy;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // reload on every state entry, otherwise count down and stick at zero
      cnt_d = state_d == state_q ? cnt_q - CNT_W'(cnt_q != '0) :
              state_d == S_RD ? CNT_W'(RD_WAIT - 1) :
              state_d == S_WR ? CNT_W'(WR_PULSE - 1) :
              state_d == S_RST ? CNT_W'(RST_PULSE - 1) :
              (state_d == S_WR_BUSY || state_d == S_RST_BUSY) ? CNT_W'(BUSY_TMO - 1) : '0;
      host_ack_d = state_q == S_DONE && !sel_q;
      glyph_ack_d = state_q == S_DONE && sel_q;
      host_err_d = state_q == S_DONE && !sel_q && err_q;
      ce_n_d = !(state_d == S_RD || state_d == S_WR);
      oe_n_d = state_d != S_RD;
      we_n_d = state_d != S_WR;
      dout_en_d = state_d == S_WR;
      rst_n_d = state_d != S_RST;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         sel_q <= 1'b0;
         err_q <= 1'b0;
         host_rdata_q <= '0;
         glyph_rdata_q <= '0;
         host_ack_q <= 1'b0;
         glyph_ack_q <= 1'b0;
         host_err_q <= 1'b0;
         ce_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         we_n_q <= 1'b1;
         rst_n_q <= 1'b1;
         dout_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         sel_q <= sel_d;
         err_q <= err_d;
         host_rdata_q <= host_rdata_d;
         glyph_rdata_q <= glyph_rdata_d;
         host_ack_q <= host_ack_d;
         glyph_ack_q <= glyph_ack_d;
         host_err_q <= host_err_d;
         ce_n_q <= ce_n_d;
         oe_n_q <= oe_n_d;
         we_n_q <= we_n_d;
         rst_n_q <= rst_n_d;
         dout_en_q <= dout_en_d;
      end
   end
   assign hostAck = host_ack_q;
   assign hostErr = host_err_q;
   assign hostRData = host_rdata_q;
   assign glyphAck = glyph_ack_q;
   assign glyphRData = glyph_rdata_q;
   assign flashAddr = addr_q;
   assign flashDout = wdata_q;
   assign flashDoutEn = dout_en_q;
   assign flashCe_n = ce_n_q;
   assign flashOe_n = oe_n_q;
   assign flashWe_n = we_n_q;
   assign flashRst_n = rst_n_q;
   assign busy = state_q != S_IDLE;
endmodule
